game_status: RTL and testbench

Game-state controller and status-bar renderer for the brick breaker. It sits downstream of the collision and block-life stages, consuming the per-block hit signals, the alive flags and a ball-lost pulse. It keeps score (3-digit BCD) and remaining lives, and sequences serve, play, life-lost, win and game-over. It feeds `ball_hold` back to the ball and paddle, and feeds a 24-bit `status_color` into the top-level colour mux alongside the paddle, block and ball colours.

---
 rtl/game_status.sv | 229 ++++++++++++++++++++++
 tb/tb_game_status.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_status.sv
// Game-state sequencer, BCD score and life counter for the brick breaker,
// plus the combinational status-bar overlay (lives, score, state divider).
module game_status #(
  parameter int LIVES_INIT   = 3,
  parameter int PAUSE_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_n,
  input  logic [9:0]  collide_block,
  input  logic [9:0]  alive,
  input  logic        ball_lost,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_pixels,
  output logic [2:0]  game_state,
  output logic        ball_hold,
  output logic        restart,
  output logic [11:0] score,
  output logic [1:0]  lives,
  output logic [23:0] status_color
);

  localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_LOST  = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [PW-1:0] pause_q, pause_d;
  logic          restart_q, restart_d;
  logic          launch_sync1_q, launch_sync2_q, launch_prev_q;
  logic [9:0]    collide_q;

  logic          press;
  logic [9:0]    hits;
  logic [3:0]    hit_cnt;
  logic [11:0]   score_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      score_q        <= 12'h000;
      lives_q        <= 2'(LIVES_INIT);
      pause_q        <= '0;
      restart_q      <= 1'b0;
      launch_sync1_q <= 1'b1;
      launch_sync2_q <= 1'b1;
      launch_prev_q  <= 1'b1;
      collide_q      <= '0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      pause_q        <= pause_d;
      restart_q      <= restart_d;
      launch_sync1_q <= launch_n;
      launch_sync2_q <= launch_sync1_q;
      launch_prev_q  <= launch_sync2_q;
      collide_q      <= collide_block;
    end
  end

  assign press = launch_prev_q & ~launch_sync2_q;
  assign hits  = collide_block & ~collide_q;

  always_comb begin
    hit_cnt = 4'd0;
    for (int i = 0; i < 10; i++) begin
      hit_cnt = hit_cnt + 4'(hits[i]);
    end
  end

  // Popcount is at most 10, so each BCD digit carries at most once.
  logic [4:0] u_sum, t_sum, h_sum, u_adj, t_adj;
  logic       u_carry, t_carry;
  always_comb begin
    u_sum   = {1'b0, score_q[3:0]} + {1'b0, hit_cnt};
    u_adj   = u_sum - 5'd10;
    u_carry = (u_sum >= 5'd10);
    t_sum   = {1'b0, score_q[7:4]} + {4'd0, u_carry};
    t_adj   = t_sum - 5'd10;
    t_carry = (t_sum >= 5'd10);
    h_sum   = {1'b0, score_q[11:8]} + {4'd0, t_carry};
    score_sum = {h_sum[3:0], (t_carry ? t_adj[3:0] : t_sum[3:0]),
                 (u_carry ? u_adj[3:0] : u_sum[3:0])};
    if (h_sum >= 5'd10) begin
      score_sum = 12'h999;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    pause_d   = pause_q;
    restart_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_SERVE;
      S_SERVE: if (press) state_d = S_PLAY;
      S_PLAY: begin
        score_d = score_sum;
        if (alive == 10'd0) begin
          state_d = S_WIN;
        end else if (ball_lost) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = S_OVER;
          end else begin
            state_d = S_LOST;
            pause_d = PAUSE_LOAD;
          end
        end
      end
      S_LOST: begin
        if (pause_q == '0) state_d = S_SERVE;
        else               pause_d = pause_q - 1'b1;
      end
      S_WIN, S_OVER: begin
        if (press) begin
          restart_d = 1'b1;
          score_d   = 12'h000;
          lives_d   = 2'(LIVES_INIT);
          state_d   = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign game_state = state_q;
  assign ball_hold  = (state_q != S_PLAY);
  assign restart    = restart_q;
  assign score      = score_q;
  assign lives      = lives_q;

  logic [31:0] xw, yw;
  assign xw = {22'd0, x};
  assign yw = {22'd0, y};

  // Digit cells: index 0 is hundreds at the left, 2 is units.
  logic [2:0] digit_on;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      localparam int X0 = 600 + 12 * gi;
      logic [3:0]  val;
      logic [6:0]  segs;  // {a,b,c,d,e,f,g}
      logic [31:0] col, row;
      logic        in_cell;
      logic        on_a, on_b, on_c, on_d, on_e, on_f, on_g;

      assign val = score_q[4*(2-gi) +: 4];

      always_comb begin
        case (val)
          4'd0:    segs = 7'b1111110;
          4'd1:    segs = 7'b0110000;
          4'd2:    segs = 7'b1101101;
          4'd3:    segs = 7'b1111001;
          4'd4:    segs = 7'b0110011;
          4'd5:    segs = 7'b1011011;
          4'd6:    segs = 7'b1011111;
          4'd7:    segs = 7'b1110000;
          4'd8:    segs = 7'b1111111;
          4'd9:    segs = 7'b1111011;
          default: segs = 7'b0000000;
        endcase
      end

      assign in_cell = (xw >= 32'(X0)) && (xw <= 32'(X0 + 7)) &&
                       (yw >= 32'd2) && (yw <= 32'd15);
      assign col = xw - 32'(X0);
      assign row = yw - 32'd2;

      assign on_a = segs[6] && (row <= 32'd1);
      assign on_b = segs[5] && (col >= 32'd6) && (row <= 32'd7);
      assign on_c = segs[4] && (col >= 32'd6) && (row >= 32'd6);
      assign on_d = segs[3] && (row >= 32'd12);
      assign on_e = segs[2] && (col <= 32'd1) && (row >= 32'd6);
      assign on_f = segs[1] && (col <= 32'd1) && (row <= 32'd7);
      assign on_g = segs[0] && (row >= 32'd6) && (row <= 32'd7);

      assign digit_on[gi] = in_cell &&
                            (on_a || on_b || on_c || on_d || on_e || on_f || on_g);
    end
  endgenerate

  logic pip_on;
  always_comb begin
    pip_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((i < int'(lives_q)) &&
          (xw >= 32'(8 + 16 * i)) && (xw <= 32'(15 + 16 * i)) &&
          (yw >= 32'd4) && (yw <= 32'd11)) begin
        pip_on = 1'b1;
      end
    end
  end

  logic [23:0] divider_color;
  always_comb begin
    case (state_q)
      S_PLAY:  divider_color = 24'h808080;
      S_WIN:   divider_color = 24'h00FF00;
      S_OVER:  divider_color = 24'hFF0000;
      default: divider_color = 24'h0000FF;
    endcase
  end

  always_comb begin
    status_color = 24'h000000;
    if (active_pixels && (yw < 32'd18)) begin
      if (|digit_on)          status_color = 24'hFFFF00;
      else if (pip_on)        status_color = 24'hFF0000;
      else if (yw >= 32'd16)  status_color = divider_color;
    end
  end

endmodule

// File: tb/tb_game_status.sv
// Directed bench for game_status: table-driven hit and overlay vectors plus
// hand-written sequences for launch, pause, game over, win and reset.
module tb_game_status;

  logic        clk;
  logic        rst;
  logic        launch_n;
  logic [9:0]  collide_block;
  logic [9:0]  alive;
  logic        ball_lost;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active_pixels;
  logic [2:0]  game_state;
  logic        ball_hold;
  logic        restart;
  logic [11:0] score;
  logic [1:0]  lives;
  logic [23:0] status_color;

  int checks = 0;
  int errors = 0;

  game_status #(.LIVES_INIT(3), .PAUSE_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .launch_n      (launch_n),
    .collide_block (collide_block),
    .alive         (alive),
    .ball_lost     (ball_lost),
    .x             (x),
    .y             (y),
    .active_pixels (active_pixels),
    .game_state    (game_state),
    .ball_hold     (ball_hold),
    .restart       (restart),
    .score         (score),
    .lives         (lives),
    .status_color  (status_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  col;
    logic [11:0] exp_score;
  } hit_vec_t;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        act;
    logic [23:0] exp_color;
  } pix_vec_t;

  hit_vec_t hit_tbl[10];
  pix_vec_t pix_tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_hits(input logic [9:0] pat);
    collide_block = pat;
    step();
    collide_block = '0;
    step();
  endtask

  task automatic press();
    launch_n = 1'b0;
    step();
    step();
    step();
    launch_n = 1'b1;
  endtask

  task automatic pix(input string name, input logic [9:0] px, input logic [9:0] py,
                     input logic act, input logic [23:0] exp);
    x = px;
    y = py;
    active_pixels = act;
    #1;
    check(name, 32'(status_color), 32'(exp));
  endtask

  task automatic lose_ball();
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
  endtask

  initial begin
    hit_tbl[0] = '{10'h001, 12'h001};
    hit_tbl[1] = '{10'h001, 12'h001};  // held level adds nothing
    hit_tbl[2] = '{10'h000, 12'h001};
    hit_tbl[3] = '{10'h3FF, 12'h011};
    hit_tbl[4] = '{10'h000, 12'h011};
    hit_tbl[5] = '{10'h0F0, 12'h015};
    hit_tbl[6] = '{10'h0F1, 12'h016};  // only bit 0 is a new edge
    hit_tbl[7] = '{10'h000, 12'h016};
    hit_tbl[8] = '{10'h1FF, 12'h025};
    hit_tbl[9] = '{10'h000, 12'h025};

    // Taken with score 0x047, lives 3, state PLAY.
    pix_tbl[0]  = '{10'd8,   10'd4,  1'b1, 24'hFF0000};
    pix_tbl[1]  = '{10'd15,  10'd11, 1'b1, 24'hFF0000};
    pix_tbl[2]  = '{10'd16,  10'd4,  1'b1, 24'h000000};
    pix_tbl[3]  = '{10'd40,  10'd4,  1'b1, 24'hFF0000};
    pix_tbl[4]  = '{10'd47,  10'd11, 1'b1, 24'hFF0000};
    pix_tbl[5]  = '{10'd56,  10'd4,  1'b1, 24'h000000};
    pix_tbl[6]  = '{10'd8,   10'd4,  1'b0, 24'h000000};
    pix_tbl[7]  = '{10'd100, 10'd16, 1'b1, 24'h808080};
    pix_tbl[8]  = '{10'd100, 10'd17, 1'b1, 24'h808080};
    pix_tbl[9]  = '{10'd100, 10'd18, 1'b1, 24'h000000};
    pix_tbl[10] = '{10'd603, 10'd2,  1'b1, 24'hFFFF00};
    pix_tbl[11] = '{10'd604, 10'd9,  1'b1, 24'h000000};
    pix_tbl[12] = '{10'd600, 10'd8,  1'b1, 24'hFFFF00};
    pix_tbl[13] = '{10'd618, 10'd8,  1'b1, 24'hFFFF00};
    pix_tbl[14] = '{10'd615, 10'd2,  1'b1, 24'h000000};
    pix_tbl[15] = '{10'd612, 10'd14, 1'b1, 24'h000000};
    pix_tbl[16] = '{10'd630, 10'd8,  1'b1, 24'hFFFF00};
    pix_tbl[17] = '{10'd624, 10'd8,  1'b1, 24'h000000};

    rst = 1'b1;
    launch_n = 1'b1;
    collide_block = '0;
    alive = 10'h3FF;
    ball_lost = 1'b0;
    x = '0;
    y = '0;
    active_pixels = 1'b0;

    // Reset and first transition
    step(); step(); step();
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_score", 32'(score), 32'h000);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_hold", 32'(ball_hold), 32'd1);
    check("rst_restart", 32'(restart), 32'd0);
    rst = 1'b0;
    step();
    check("serve_after_rst", 32'(game_state), 32'd1);
    pix("pip0_after_rst", 10'd8, 10'd4, 1'b1, 24'hFF0000);

    // Launch latency: PLAY exactly three edges after the fall
    launch_n = 1'b0;
    step();
    check("launch_n1", 32'(game_state), 32'd1);
    step();
    check("launch_n2", 32'(game_state), 32'd1);
    step();
    launch_n = 1'b1;
    check("launch_n3", 32'(game_state), 32'd2);
    check("play_hold", 32'(ball_hold), 32'd0);

    for (int i = 0; i < 10; i++) begin
      collide_block = hit_tbl[i].col;
      step();
      check($sformatf("hit_row%0d", i), 32'(score), 32'(hit_tbl[i].exp_score));
    end

    for (int i = 0; i < 7; i++) pulse_hits(10'h3FF);
    for (int i = 0; i < 3; i++) pulse_hits(10'h001);
    check("score_098", 32'(score), 32'h098);
    collide_block = 10'h007;
    step();
    check("score_101", 32'(score), 32'h101);
    step();
    check("score_101_held", 32'(score), 32'h101);
    collide_block = '0;
    step();

    // LOST pause of exactly 8 cycles, press ignored
    lose_ball();
    check("lost_state", 32'(game_state), 32'd3);
    check("lost_lives", 32'(lives), 32'd2);
    check("lost_hold", 32'(ball_hold), 32'd1);
    launch_n = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      if (k == 2) launch_n = 1'b1;
      check($sformatf("lost_cycle%0d", k), 32'(game_state), 32'd3);
    end
    step();
    check("lost_to_serve", 32'(game_state), 32'd1);
    step(); step();
    check("lost_press_ignored", 32'(game_state), 32'd1);

    // Outside PLAY: ball_lost and hits ignored
    lose_ball();
    step();
    check("serve_lost_ignored", 32'(lives), 32'd2);
    check("serve_state_kept", 32'(game_state), 32'd1);
    pulse_hits(10'h3FF);
    check("serve_hits_ignored", 32'(score), 32'h101);

    // Down to one life, then game over
    press();
    check("play2", 32'(game_state), 32'd2);
    lose_ball();
    check("lives_1", 32'(lives), 32'd1);
    for (int k = 0; k < 8; k++) step();
    check("serve2", 32'(game_state), 32'd1);
    press();
    lose_ball();
    check("over_state", 32'(game_state), 32'd5);
    check("over_lives", 32'(lives), 32'd0);
    check("over_hold", 32'(ball_hold), 32'd1);
    pix("over_divider", 10'd100, 10'd16, 1'b1, 24'hFF0000);
    pix("over_no_pip", 10'd8, 10'd4, 1'b1, 24'h000000);
    pulse_hits(10'h3FF);
    check("over_score_frozen", 32'(score), 32'h101);
    press();
    check("over_restart", 32'(restart), 32'd1);
    check("over_to_serve", 32'(game_state), 32'd1);
    check("over_score_clr", 32'(score), 32'h000);
    check("over_lives_reload", 32'(lives), 32'd3);
    step();
    check("restart_one_cycle", 32'(restart), 32'd0);

    // Reset in the middle of a pause
    press();
    pulse_hits(10'h007);
    check("score_003", 32'(score), 32'h003);
    lose_ball();
    step(); step(); step();
    check("midpause_lost", 32'(game_state), 32'd3);
    rst = 1'b1;
    step();
    check("midpause_rst_state", 32'(game_state), 32'd0);
    check("midpause_rst_lives", 32'(lives), 32'd3);
    check("midpause_rst_score", 32'(score), 32'h000);
    check("midpause_rst_hold", 32'(ball_hold), 32'd1);
    rst = 1'b0;
    step();
    check("midpause_serve", 32'(game_state), 32'd1);

    // Overlay at score 0x047
    press();
    for (int i = 0; i < 4; i++) pulse_hits(10'h3FF);
    for (int i = 0; i < 7; i++) pulse_hits(10'h001);
    check("score_047", 32'(score), 32'h047);
    for (int i = 0; i < 18; i++) begin
      pix($sformatf("pix_row%0d", i), pix_tbl[i].px, pix_tbl[i].py,
          pix_tbl[i].act, pix_tbl[i].exp_color);
    end

    // Saturation at 999
    for (int i = 0; i < 95; i++) pulse_hits(10'h3FF);
    pulse_hits(10'h001);
    check("score_998", 32'(score), 32'h998);
    pulse_hits(10'h01F);
    check("score_sat_999", 32'(score), 32'h999);
    pulse_hits(10'h3FF);
    check("score_stay_999", 32'(score), 32'h999);

    // Board cleared together with ball_lost: WIN wins
    alive = 10'h000;
    ball_lost = 1'b1;
    step();
    ball_lost = 1'b0;
    check("win_state", 32'(game_state), 32'd4);
    check("win_lives", 32'(lives), 32'd3);
    pix("win_divider", 10'd100, 10'd17, 1'b1, 24'h00FF00);
    press();
    check("win_restart", 32'(restart), 32'd1);
    check("win_to_serve", 32'(game_state), 32'd1);
    check("win_score_clr", 32'(score), 32'h000);
    alive = 10'h3FF;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
